// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect Four move sequencer.
package c4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SETTLE = 2'd2,
    OVER   = 2'd3
  } state_e;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_DROP  = 2;
  localparam int unsigned BTN_W     = 3;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

endpackage

// File: rtl/c4_move_sequencer_if.sv
// Command/status link between the move sequencer (master) and the game core (slave).
interface c4_move_sequencer_if;
  logic core_turn;
  logic core_won;
  logic core_left;
  logic core_right;
  logic core_start;
  logic core_sel;

  modport master (
    input  core_turn, core_won,
    output core_left, core_right, core_start, core_sel
  );

  modport slave (
    output core_turn, core_won,
    input  core_left, core_right, core_start, core_sel
  );
endinterface

// File: rtl/c4_btn_conditioner.sv
// One raw button: 2-flop synchroniser, counter debounce and press-edge detect.
module c4_btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips on the DEBOUNCE_CYC-th consecutive differing sample; any agreeing sample restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  // Press is the accepted 0->1 transition, seen the cycle before level_q rises so the registered command lands with it.
  assign press = level_d & ~level_q;

endmodule

// File: rtl/c4_move_sequencer.sv
// Turns both players' raw buttons into single-cycle left/right/start commands for the game core,
// with turn granting, per-turn timeout auto-drop, rejected-drop detection and win freeze.
module c4_move_sequencer
  import c4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned TURN_CYC     = 1000,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BTN_W-1:0]                  p1_btn,
  input  logic [BTN_W-1:0]                  p2_btn,
  input  logic                              first_sel,
  c4_move_sequencer_if.master               core,
  output logic                              active_player,
  output logic [$clog2(TURN_CYC+1)-1:0]     time_left,
  output logic                              move_rejected,
  output logic                              auto_drop,
  output logic                              game_over
);

  localparam int unsigned TW = $clog2(TURN_CYC + 1);
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TL_FULL     = TW'(TURN_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [BTN_W-1:0]   p1_press, p2_press, grant;
  logic [2*BTN_W-1:0] lvl_unused;

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    c4_btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_p1 (
      .clk   (clk),
      .reset (reset),
      .raw   (p1_btn[i]),
      .level (lvl_unused[i]),
      .press (p1_press[i])
    );
    c4_btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_p2 (
      .clk   (clk),
      .reset (reset),
      .raw   (p2_btn[i]),
      .level (lvl_unused[BTN_W+i]),
      .press (p2_press[i])
    );
  end

  state_e        state_q, state_d;
  logic          prev_turn_q, prev_turn_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] time_left_q, time_left_d;
  logic          left_q, left_d, right_q, right_d, start_q, start_d;
  logic          auto_q, auto_d, rej_q, rej_d, over_q, over_d;
  logic          sel_q, sel_d, active_q, active_d, won_prev_q, won_prev_d;
  logic          cmd_ok;

  always_comb begin
    state_d      = state_q;
    prev_turn_d  = prev_turn_q;
    settle_cnt_d = settle_cnt_q;
    time_left_d  = time_left_q;
    left_d       = 1'b0;
    right_d      = 1'b0;
    start_d      = 1'b0;
    auto_d       = 1'b0;
    rej_d        = 1'b0;
    sel_d        = first_sel;
    won_prev_d   = core.core_won;
    grant        = (core.core_turn == PLAYER2) ? p2_press : p1_press;
    // A command on the previous cycle blocks this cycle's edges so commands never run back to back.
    cmd_ok       = ~(left_q | right_q | start_q);

    unique case (state_q)
      IDLE: begin
        if (p1_press[BTN_DROP] | p2_press[BTN_DROP]) begin
          start_d     = 1'b1;
          time_left_d = TL_FULL;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (cmd_ok && grant[BTN_LEFT]) begin
          left_d      = 1'b1;
          time_left_d = TL_FULL;
        end else if (cmd_ok && grant[BTN_RIGHT]) begin
          right_d     = 1'b1;
          time_left_d = TL_FULL;
        end else if (cmd_ok && grant[BTN_DROP]) begin
          start_d      = 1'b1;
          time_left_d  = TL_FULL;
          prev_turn_d  = core.core_turn;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else if (time_left_q <= TW'(1)) begin
          start_d      = 1'b1;
          auto_d       = 1'b1;
          time_left_d  = '0;
          prev_turn_d  = core.core_turn;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          time_left_d = time_left_q - TW'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          if (core.core_won) begin
            state_d = OVER;
          end else begin
            state_d     = PLAY;
            time_left_d = TL_FULL;
            rej_d       = (core.core_turn == prev_turn_q);
          end
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      OVER: begin
      end
      default: state_d = IDLE;
    endcase

    // A fresh win outside IDLE freezes everything, overriding whatever was decided above.
    if ((state_q != IDLE) && core.core_won && !won_prev_q) begin
      state_d = OVER;
      left_d  = 1'b0;
      right_d = 1'b0;
      start_d = 1'b0;
      auto_d  = 1'b0;
      rej_d   = 1'b0;
    end

    over_d   = (state_d == OVER);
    active_d = (state_d == PLAY) ? core.core_turn : active_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_turn_q  <= 1'b0;
      settle_cnt_q <= '0;
      time_left_q  <= TL_FULL;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      start_q      <= 1'b0;
      auto_q       <= 1'b0;
      rej_q        <= 1'b0;
      over_q       <= 1'b0;
      sel_q        <= 1'b0;
      active_q     <= 1'b0;
      won_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_turn_q  <= prev_turn_d;
      settle_cnt_q <= settle_cnt_d;
      time_left_q  <= time_left_d;
      left_q       <= left_d;
      right_q      <= right_d;
      start_q      <= start_d;
      auto_q       <= auto_d;
      rej_q        <= rej_d;
      over_q       <= over_d;
      sel_q        <= sel_d;
      active_q     <= active_d;
      won_prev_q   <= won_prev_d;
    end
  end

  assign core.core_left  = left_q;
  assign core.core_right = right_q;
  assign core.core_start = start_q;
  assign core.core_sel   = sel_q;
  assign active_player   = active_q;
  assign time_left       = time_left_q;
  assign move_rejected   = rej_q;
  assign auto_drop       = auto_q;
  assign game_over       = over_q;

endmodule

// File: tb/tb_c4_move_sequencer.sv
// Scoreboard bench for c4_move_sequencer: expected commands are queued with their cycle as stimulus
// is driven, and every command the DUT issues is popped and compared.
module tb_c4_move_sequencer;

  localparam int unsigned DEB    = 4;
  localparam int unsigned TURN   = 10;
  localparam int unsigned SETTLE = 2;

  localparam logic [3:0] C_LEFT  = 4'b0001;
  localparam logic [3:0] C_START = 4'b0100;
  localparam logic [3:0] C_AUTO  = 4'b1100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] p1_btn = 3'b000;
  logic [2:0] p2_btn = 3'b000;
  logic       first_sel = 1'b0;
  logic       active_player, move_rejected, auto_drop, game_over;
  logic [$clog2(TURN+1)-1:0] time_left;

  c4_move_sequencer_if core_if ();

  c4_move_sequencer #(
    .DEBOUNCE_CYC (DEB),
    .TURN_CYC     (TURN),
    .SETTLE_CYC   (SETTLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .p1_btn        (p1_btn),
    .p2_btn        (p2_btn),
    .first_sel     (first_sel),
    .core          (core_if),
    .active_player (active_player),
    .time_left     (time_left),
    .move_rejected (move_rejected),
    .auto_drop     (auto_drop),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;   // core reaction to a start: 0 none, 1 toggle turn, 2 reject, 3 win two cycles later
  logic won_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural core: owns core_turn/core_won and reacts to starts according to mode.
  always @(negedge clk) begin
    if (reset) begin
      core_if.core_turn = 1'b0;
      core_if.core_won  = 1'b0;
      won_arm           = 1'b0;
    end else begin
      if (won_arm) begin
        core_if.core_won = 1'b1;
        won_arm          = 1'b0;
      end
      if (core_if.core_start) begin
        if (mode == 1) core_if.core_turn = ~core_if.core_turn;
        else if (mode == 3) won_arm = 1'b1;
      end
    end
  end

  // Every issued command must match the head of the scoreboard, code and cycle.
  always @(negedge clk) begin : mon
    logic [3:0] got;
    exp_t       e;
    if (!reset) begin
      got = {auto_drop, core_if.core_start, core_if.core_right, core_if.core_left};
      if (got != 4'd0) begin
        if (sb.size() == 0) begin
          check("unexpected_cmd", int'(got), 0);
        end else begin
          e = sb.pop_front();
          check("cmd_code", int'(got), int'(e.code));
          check("cmd_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_left"},   int'(core_if.core_left), 0);
    check({tag, "_right"},  int'(core_if.core_right), 0);
    check({tag, "_start"},  int'(core_if.core_start), 0);
    check({tag, "_sel"},    int'(core_if.core_sel), 0);
    check({tag, "_active"}, int'(active_player), 0);
    check({tag, "_tleft"},  int'(time_left), int'(TURN));
    check({tag, "_rej"},    int'(move_rejected), 0);
    check({tag, "_auto"},   int'(auto_drop), 0);
    check({tag, "_over"},   int'(game_over), 0);
  endtask

  initial begin
    int k, g, h, r;

    first_sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick_to(cyc + 1);
    check("core_sel", int'(core_if.core_sel), 1);
    first_sel = 1'b0;

    // Bouncing p1 drop in IDLE: one start, 2+DEB cycles after the last raw edge.
    tick_to(cyc + 1);
    k = cyc;
    p1_btn = 3'b100;
    tick_to(k + 1);
    p1_btn = 3'b000;
    tick_to(k + 2);
    p1_btn = 3'b100;
    g = k + 2 + 2 + int'(DEB);
    expect_cmd(C_START, g);

    // Idle through a whole turn: p2 left is not granted, timeout auto-drops, core toggles turn.
    tick_to(g + 1);
    mode   = 1;
    p1_btn = 3'b000;
    p2_btn = 3'b001;
    expect_cmd(C_AUTO, g + 10);
    check("tleft_g1", int'(time_left), 9);
    check("active_g1", int'(active_player), 0);
    tick_to(g + 7);
    p2_btn = 3'b000;
    tick_to(g + 10);
    check("tleft_zero", int'(time_left), 0);
    check("auto_pulse", int'(auto_drop), 1);
    tick_to(g + 12);
    check("tleft_reload", int'(time_left), int'(TURN));
    check("active_p2", int'(active_player), 1);
    check("no_rej", int'(move_rejected), 0);

    // p2 granted: simultaneous left+right+drop gives left only; p1 left ignored.
    tick_to(g + 13);
    p2_btn = 3'b111;
    p1_btn = 3'b001;
    expect_cmd(C_LEFT, g + 19);
    tick_to(g + 18);
    check("tleft_g18", int'(time_left), 4);
    tick_to(g + 19);
    check("tleft_cmd", int'(time_left), int'(TURN));
    p2_btn = 3'b000;
    p1_btn = 3'b000;

    // Auto-drop into a full column: turn unchanged, rejection pulse, p2 keeps the turn.
    tick_to(g + 20);
    mode = 2;
    expect_cmd(C_AUTO, g + 29);
    tick_to(g + 31);
    check("rej_pulse", int'(move_rejected), 1);
    check("rej_active", int'(active_player), 1);
    check("rej_tleft", int'(time_left), int'(TURN));
    mode   = 3;
    p2_btn = 3'b100;
    expect_cmd(C_START, g + 37);
    tick_to(g + 32);
    check("rej_once", int'(move_rejected), 0);

    // Winning drop: game over, then nobody can issue commands.
    tick_to(g + 37);
    check("tleft_drop", int'(time_left), int'(TURN));
    tick_to(g + 38);
    check("over_early", int'(game_over), 0);
    tick_to(g + 39);
    check("over_set", int'(game_over), 1);
    tick_to(g + 40);
    p2_btn = 3'b001;
    p1_btn = 3'b101;
    tick_to(g + 50);
    check("over_hold", int'(game_over), 1);
    check("over_silent", sb.size(), 0);
    p1_btn = 3'b000;
    p2_btn = 3'b000;

    // Reset clears the win; new game started by p2, p1 (turn 0) tested for priority.
    reset = 1'b1;
    mode  = 0;
    #1;
    check_reset_outputs("rst_over");
    tick_to(cyc + 3);
    reset = 1'b0;
    r = cyc;
    tick_to(r + 1);
    p2_btn = 3'b100;
    h = r + 1 + 2 + int'(DEB);
    expect_cmd(C_START, h);
    tick_to(h + 1);
    mode   = 1;
    p2_btn = 3'b001;
    tick_to(h + 2);
    p1_btn = 3'b111;
    expect_cmd(C_LEFT, h + 8);
    tick_to(h + 7);
    check("tleft_h7", int'(time_left), 3);
    p2_btn = 3'b000;
    tick_to(h + 8);
    check("tleft_h8", int'(time_left), int'(TURN));
    check("active_p1", int'(active_player), 0);
    p1_btn = 3'b000;
    expect_cmd(C_AUTO, h + 18);
    tick_to(h + 18);
    check("auto_h18", int'(auto_drop), 1);

    // Reset in the middle of SETTLE, then the first p2 drop starts a new game.
    tick_to(h + 19);
    reset = 1'b1;
    mode  = 0;
    #1;
    check_reset_outputs("rst_settle");
    tick_to(cyc + 3);
    reset = 1'b0;
    r = cyc;
    tick_to(r + 1);
    p2_btn = 3'b100;
    expect_cmd(C_START, r + 1 + 2 + int'(DEB));
    tick_to(r + 1 + 2 + int'(DEB) + 1);
    p2_btn = 3'b000;
    check("new_game_active", int'(active_player), 0);
    tick_to(cyc + 4);
    check("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c4_move_sequencer.md
Name: c4_move_sequencer

Overview:
- Sits between the two players' raw button sets and the Connect Four game core.
- Conditions each button: 2-flop synchroniser, debounce, rising-edge detect.
- Grants commands only to the player whose turn it is, and issues single-cycle left/right/start commands to the core.
- Enforces a per-turn timeout with an auto-drop, detects drops rejected on a full column, and freezes input once the core reports a win.

Parameters:
- DEBOUNCE_CYC, 16, consecutive stable samples before a button level is accepted.
- TURN_CYC, 1000, cycles a player may idle in PLAY before an auto-drop at the current column.
- SETTLE_CYC, 2, cycles to wait after a drop before sampling core_turn/core_won.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- p1_btn  in  3  player 1 raw buttons {drop,right,left}, asynchronous.
- p2_btn  in  3  player 2 raw buttons {drop,right,left}, asynchronous.
- first_sel  in  1  first mover select (0 = player 1), passed through to the core.
- core_turn  in  1  core player_turn (0 = player 1).
- core_won  in  1  core won flag.
- core_left  out  1  one-cycle left command.
- core_right  out  1  one-cycle right command.
- core_start  out  1  one-cycle start/drop command.
- core_sel  out  1  registered copy of first_sel.
- active_player  out  1  player currently granted (equals core_turn while in PLAY).
- time_left  out  $clog2(TURN_CYC+1)  remaining turn cycles, saturating at 0.
- move_rejected  out  1  one-cycle pulse when a drop did not change the turn and no win followed.
- auto_drop  out  1  one-cycle pulse coincident with a timeout-generated core_start.
- game_over  out  1  level, high in OVER.

Behaviour:
- Reset values:
  - All outputs 0, except time_left = TURN_CYC.
  - State IDLE.
  - Debounce counters 0; debounced levels 0; synchronisers cleared.
- Conditioner:
  - Accepted level changes after DEBOUNCE_CYC identical synchronised samples.
  - Press edge = accepted 0->1; one-cycle pulse. Total latency raw->edge = 2 + DEBOUNCE_CYC cycles.
- IDLE:
  - Any player's drop edge -> core_start=1 for one cycle -> PLAY; time_left=TURN_CYC.
  - Left/right edges are ignored.
- PLAY: edges considered only from player core_turn; the other player's edges are dropped silently.
  - Priority among simultaneous granted edges: left > right > drop. Exactly one command per cycle; losing edges are discarded, not queued.
  - left -> core_left; right -> core_right. Column clamping is the core's job. time_left reloads TURN_CYC on every command.
  - drop -> core_start; latch prev_turn=core_turn -> SETTLE.
  - time_left decrements each cycle without a command. Reaching 0 -> core_start and auto_drop the same cycle -> SETTLE.
- SETTLE: counts SETTLE_CYC cycles; all edges are discarded. At expiry, in order:
  - core_won=1 -> OVER.
  - Else core_turn != prev_turn -> PLAY, time_left=TURN_CYC.
  - Else -> move_rejected pulse -> PLAY, time_left=TURN_CYC (same player retries).
- OVER: no commands issued; game_over=1; leaves only on reset.
- core_won rising in any state other than IDLE -> OVER next cycle, overriding any pending command.
- core_sel = first_sel registered each cycle (the core samples it while idle).
- Outputs core_left/right/start are registered, mutually exclusive, never high two cycles in a row.
- Reset mid-SETTLE or mid-debounce:
  - Immediate return to reset values.
  - No stray command on the cycle after reset release; the synchroniser restarts from 0.

Decomposition:
- Shared package c4_pkg: state enum (IDLE, PLAY, SETTLE, OVER); button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_DROP=2; PLAYER1=1'b0, PLAYER2=1'b1.
- Sub-module c4_btn_conditioner (parameter DEBOUNCE_CYC; ports clk, reset, raw, level, press): six instances.

Test Plan:
- DEBOUNCE_CYC=4: p1 drop bouncing 1-0-1 within 3 cycles, then stable -> exactly one core_start, 6 cycles after the last edge; IDLE->PLAY.
- PLAY, core_turn=0: p2 left press -> no command. p1 left+right+drop pressed in the same cycle -> core_left only; time_left reloads.
- TURN_CYC=10: no presses -> on the 10th cycle core_start=1 and auto_drop=1; after SETTLE, core_turn toggles -> time_left=10.
- Core model keeps core_turn unchanged after a drop (full column) -> move_rejected pulse after SETTLE_CYC; p1 still granted.
- core_won=1 two cycles after a drop -> game_over=1; subsequent presses from both players produce no commands until reset.
- reset asserted during SETTLE -> all outputs 0, state IDLE; first p2 drop after release -> core_start.
